// File: rtl/fr_adder_ksp.sv
// fr_adder_ksp: pipelined sign-magnitude adder built on a Kogge-Stone prefix carry network.
// Latency LAT = 3 + clog2(WIDTH) cycles: swap/sign, G0/P0, clog2(WIDTH) prefix levels, sum.
// Backpressure: one global advance (adv = !out_valid || out_ready) freezes every stage; in_ready = adv.
//
// Ports:
//   clock, reset            single rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready     operand handshake (accept when both high)
//   in1, in2                unsigned operand magnitudes (WIDTH bits)
//   sign_in1, sign_in2      operand signs, 1 = negative
//   in_tag                  opaque side-band tag, returned unchanged with the result
//   out_valid / out_ready   result handshake
//   out                     result magnitude (WIDTH bits)
//   adder_out_sign          result sign (never negative zero for cancelling operands)
//   overflow_signal         carry-out of a same-sign magnitude add, 0 for subtractions
//   out_tag                 tag travelling with the result
//   out_lzc                 leading-zero count of out; present only when FR_ADDER_LZC_EN is defined
//
// Build option: define FR_ADDER_LZC_EN to add the out_lzc output (WIDTH when out = 0).
module fr_adder_ksp #(
  parameter int WIDTH = 24,
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sign_in1,
  input  logic             sign_in2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             adder_out_sign,
  output logic             overflow_signal,
  output logic [TAG_W-1:0] out_tag
`ifdef FR_ADDER_LZC_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] out_lzc
`endif
);

  // Total latency and the number of prefix levels it implies.
  localparam int LAT = 3 + $clog2(WIDTH);
  localparam int LVL = LAT - 3;

  // ---------------------------------------------------------------------------
  // Global advance. Every register in the pipe (data, valid, tag) loads only
  // when adv is high, so a stalled output freezes the whole pipe in place and
  // bubbles keep their positions.
  // ---------------------------------------------------------------------------
  logic adv;
  logic out_valid_q;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------------------
  // Stage 1: swap / sign.
  // For differing signs the larger magnitude is placed in operand a so that the
  // later a + ~b + 1 always yields a non-negative difference; the result sign is
  // the sign of the larger magnitude, and forced positive on exact cancellation.
  // ---------------------------------------------------------------------------
  logic             s1_vld_q,  s1_vld_d;
  logic [WIDTH-1:0] s1_a_q,    s1_a_d;
  logic [WIDTH-1:0] s1_b_q,    s1_b_d;
  logic             s1_sub_q,  s1_sub_d;
  logic             s1_sign_q, s1_sign_d;
  logic [TAG_W-1:0] s1_tag_q,  s1_tag_d;

  always_comb begin
    s1_vld_d  = in_valid;
    s1_tag_d  = in_tag;
    s1_sub_d  = sign_in1 ^ sign_in2;
    s1_a_d    = in1;
    s1_b_d    = in2;
    s1_sign_d = sign_in1;
    if (s1_sub_d) begin
      if (in1 > in2) begin
        s1_a_d    = in1;
        s1_b_d    = in2;
        s1_sign_d = sign_in1;
      end else if (in2 > in1) begin
        s1_a_d    = in2;
        s1_b_d    = in1;
        s1_sign_d = sign_in2;
      end else begin
        // Equal magnitudes with opposite signs: result is +0.
        s1_a_d    = in1;
        s1_b_d    = in2;
        s1_sign_d = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prefix pipeline. Index 0 holds the bitwise G0/P0 stage; index k (1..LVL)
  // holds the result of prefix level k, which combines spans of 2^(k-1) bits.
  //   g_q  : group generate, after level LVL g[i] is the carry out of bit i
  //   p_q  : group propagate, not needed after the last level
  //   hs_q : bitwise half sum a ^ b_eff, needed unchanged by the sum stage
  // The subtraction carry-in is folded into bit 0's generate, so the network
  // never needs a separate carry-in input; sub_q still supplies c0 to bit 0.
  // ---------------------------------------------------------------------------
  logic [LVL:0][WIDTH-1:0]   g_q,    g_d;
  logic [LVL-1:0][WIDTH-1:0] p_q,    p_d;
  logic [LVL:0][WIDTH-1:0]   hs_q,   hs_d;
  logic [LVL:0]              vld_q,  vld_d;
  logic [LVL:0]              sub_q,  sub_d;
  logic [LVL:0]              sign_q, sign_d;
  logic [LVL:0][TAG_W-1:0]   tag_q,  tag_d;
  logic [WIDTH-1:0]          b_eff;

  always_comb begin
    // Side-band bits simply shift down the pipe alongside the data.
    vld_d  = {vld_q[LVL-1:0],  s1_vld_q};
    sub_d  = {sub_q[LVL-1:0],  s1_sub_q};
    sign_d = {sign_q[LVL-1:0], s1_sign_q};
    tag_d  = {tag_q[LVL-1:0],  s1_tag_q};
    hs_d   = {hs_q[LVL-1:0],   {WIDTH{1'b0}}};
    g_d    = '0;
    p_d    = '0;

    // G0/P0: subtraction uses the ones' complement of the smaller operand.
    b_eff     = s1_sub_q ? ~s1_b_q : s1_b_q;
    hs_d[0]   = s1_a_q ^ b_eff;
    g_d[0]    = s1_a_q & b_eff;
    g_d[0][0] = g_d[0][0] | (hs_d[0][0] & s1_sub_q);
    p_d[0]    = hs_d[0];

    // Kogge-Stone generate combine: G'[i] = G[i] | P[i] & G[i-d].
    // Bits below d are already final and pass through untouched.
    for (int k = 1; k <= LVL; k++) begin
      g_d[k] = g_q[k-1] | (p_q[k-1] & (g_q[k-1] << (1 << (k - 1))));
    end

    // Propagate combine. Bits below d become 0; later levels only read
    // propagate bits at positions >= 2d, so their value does not matter.
    for (int k = 1; k < LVL; k++) begin
      p_d[k] = p_q[k-1] & (p_q[k-1] << (1 << (k - 1)));
    end
  end

  // ---------------------------------------------------------------------------
  // Sum stage. Carry into bit i is the final group generate of bit i-1; the
  // carry into bit 0 is the subtraction carry-in. A subtraction's carry-out is
  // an artefact of two's-complement negation, so overflow is masked there.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;
  logic [WIDTH-1:0] out_q;
  logic             out_sign_q;
  logic             ovf_q;
  logic [TAG_W-1:0] out_tag_q;

  always_comb begin
    sum_d = hs_q[LVL] ^ {g_q[LVL][WIDTH-2:0], sub_q[LVL]};
    ovf_d = g_q[LVL][WIDTH-1] & ~sub_q[LVL];
  end

`ifdef FR_ADDER_LZC_EN
  localparam int LZW = $clog2(WIDTH + 1);

  logic [LZW-1:0] lzc_d;
  logic [LZW-1:0] lzc_q;

  // Leading-zero count of the next sum; the highest set bit wins because it
  // is visited last. An all-zero sum leaves the default of WIDTH.
  always_comb begin
    lzc_d = LZW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (sum_d[i]) begin
        lzc_d = LZW'(WIDTH - 1 - i);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lzc_q <= '0;
    end else if (adv) begin
      lzc_q <= lzc_d;
    end
  end

  assign out_lzc = lzc_q;
`endif

  // ---------------------------------------------------------------------------
  // State registers. Reset clears every valid bit immediately, which discards
  // all in-flight operations, and zeroes the datapath.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_vld_q    <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_sub_q    <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_tag_q    <= '0;
      g_q         <= '0;
      p_q         <= '0;
      hs_q        <= '0;
      vld_q       <= '0;
      sub_q       <= '0;
      sign_q      <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_sign_q  <= 1'b0;
      ovf_q       <= 1'b0;
      out_tag_q   <= '0;
    end else if (adv) begin
      s1_vld_q    <= s1_vld_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_sub_q    <= s1_sub_d;
      s1_sign_q   <= s1_sign_d;
      s1_tag_q    <= s1_tag_d;
      g_q         <= g_d;
      p_q         <= p_d;
      hs_q        <= hs_d;
      vld_q       <= vld_d;
      sub_q       <= sub_d;
      sign_q      <= sign_d;
      tag_q       <= tag_d;
      out_valid_q <= vld_q[LVL];
      out_q       <= sum_d;
      out_sign_q  <= sign_q[LVL];
      ovf_q       <= ovf_d;
      out_tag_q   <= tag_q[LVL];
    end
  end

  assign out_valid       = out_valid_q;
  assign out             = out_q;
  assign adder_out_sign  = out_sign_q;
  assign overflow_signal = ovf_q;
  assign out_tag         = out_tag_q;

endmodule

// File: tb/tb_fr_adder_ksp.sv
// tb_fr_adder_ksp: directed and regression bench for fr_adder_ksp at WIDTH=24 and WIDTH=8.
// Latency is measured from the cycle an operand is presented to the cycle out_valid is seen.
// Output stalls, mid-flight reset and back-to-back streams are exercised.
module tb_fr_adder_ksp;

  logic clk;
  logic rst;

  // WIDTH=24 instance
  logic        v24, rdy24, sa24, sb24, ov24, ordy24, sg24, of24;
  logic [23:0] a24, b24, o24;
  logic [3:0]  tag24, ot24;
  // WIDTH=8 instance
  logic        v8, rdy8, sa8, sb8, ov8, ordy8, sg8, of8;
  logic [7:0]  a8, b8, o8;
  logic [3:0]  tag8, ot8;
`ifdef FR_ADDER_LZC_EN
  logic [4:0]  lz24;
  logic [3:0]  lz8;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  fr_adder_ksp #(.WIDTH(24), .TAG_W(4)) u_dut24 (
    .clock(clk), .reset(rst),
    .in_valid(v24), .in_ready(rdy24),
    .in1(a24), .in2(b24), .sign_in1(sa24), .sign_in2(sb24), .in_tag(tag24),
    .out_valid(ov24), .out_ready(ordy24),
    .out(o24), .adder_out_sign(sg24), .overflow_signal(of24), .out_tag(ot24)
`ifdef FR_ADDER_LZC_EN
    , .out_lzc(lz24)
`endif
  );

  fr_adder_ksp #(.WIDTH(8), .TAG_W(4)) u_dut8 (
    .clock(clk), .reset(rst),
    .in_valid(v8), .in_ready(rdy8),
    .in1(a8), .in2(b8), .sign_in1(sa8), .sign_in2(sb8), .in_tag(tag8),
    .out_valid(ov8), .out_ready(ordy8),
    .out(o8), .adder_out_sign(sg8), .overflow_signal(of8), .out_tag(ot8)
`ifdef FR_ADDER_LZC_EN
    , .out_lzc(lz8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  typedef struct packed {
    logic        ovf;
    logic        sign;
    logic [63:0] mag;
  } res_t;

  // Plain sign-magnitude arithmetic reference for a w-bit adder.
  function automatic res_t ref_add(input int w, input logic [63:0] a, input logic sa,
                                   input logic [63:0] b, input logic sb);
    res_t        r;
    logic [64:0] s;
    r = '0;
    if (sa == sb) begin
      s      = {1'b0, a} + {1'b0, b};
      r.ovf  = s[w];
      r.mag  = s[63:0] & ((64'd1 << w) - 64'd1);
      r.sign = sa;
    end else if (a > b) begin
      r.mag  = a - b;
      r.sign = sa;
    end else if (b > a) begin
      r.mag  = b - a;
      r.sign = sb;
    end
    return r;
  endfunction

  // One operation through the 24-bit unit with out_ready held high.
  task automatic run24(input string nm, input logic [23:0] a, input logic sa,
                       input logic [23:0] b, input logic sb, input logic [3:0] t,
                       input logic [23:0] eo, input logic es, input logic ef, input int elz);
    int lat;
    ordy24 = 1'b1;
    v24 = 1'b1; a24 = a; b24 = b; sa24 = sa; sb24 = sb; tag24 = t;
    for (lat = 1; lat <= 20; lat++) begin
      @(negedge clk);
      if (lat == 1) v24 = 1'b0;
      if (ov24) break;
    end
    check({nm, "_latency"}, 64'(lat), 64'd8);
    check({nm, "_out"},  {40'd0, o24}, {40'd0, eo});
    check({nm, "_sign"}, {63'd0, sg24}, {63'd0, es});
    check({nm, "_ovf"},  {63'd0, of24}, {63'd0, ef});
    check({nm, "_tag"},  {60'd0, ot24}, {60'd0, t});
`ifdef FR_ADDER_LZC_EN
    check({nm, "_lzc"},  {59'd0, lz24}, 64'(elz));
`endif
    @(negedge clk);
  endtask

  task automatic run8(input string nm, input logic [7:0] a, input logic sa,
                      input logic [7:0] b, input logic sb, input logic [3:0] t,
                      input logic [7:0] eo, input logic es, input logic ef, input int elz);
    int lat;
    ordy8 = 1'b1;
    v8 = 1'b1; a8 = a; b8 = b; sa8 = sa; sb8 = sb; tag8 = t;
    for (lat = 1; lat <= 20; lat++) begin
      @(negedge clk);
      if (lat == 1) v8 = 1'b0;
      if (ov8) break;
    end
    check({nm, "_latency"}, 64'(lat), 64'd6);
    check({nm, "_res"}, {50'd0, ot8, of8, sg8, o8}, {50'd0, t, ef, es, eo});
`ifdef FR_ADDER_LZC_EN
    check({nm, "_lzc"}, {60'd0, lz8}, 64'(elz));
`endif
    @(negedge clk);
  endtask

  // 16 back-to-back operations with a 3-cycle output stall mid-stream.
  task automatic b2b24();
    logic [63:0] expq[$];
    int          sent;
    int          got;
    logic        rdy;
    res_t        r;
    logic [23:0] a, b;
    logic        sa, sb;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 120 && got < 16; cyc++) begin
      rdy = !(cyc >= 12 && cyc <= 14);
      if (cyc == 13 || cyc == 14) check("b2b_in_ready_stalled", {63'd0, rdy24}, 64'd0);
      if (ov24) begin
        if (expq.size() == 0) begin
          check("b2b_extra_result", 64'd1, 64'd0);
        end else begin
          check("b2b_result", {34'd0, ot24, of24, sg24, o24}, expq[0]);
          if (rdy) begin
            void'(expq.pop_front());
            got++;
          end
        end
      end
      ordy24 = rdy;
      if (sent < 16) begin
        a  = 24'(sent * 32'h0F1357 + 5);
        b  = 24'(sent * 32'h031F00 + 1);
        sa = sent[0];
        sb = sent[1];
        v24 = 1'b1; a24 = a; b24 = b; sa24 = sa; sb24 = sb; tag24 = 4'(sent);
        if (!ov24 || rdy) begin
          r = ref_add(24, {40'd0, a}, sa, {40'd0, b}, sb);
          expq.push_back({34'd0, 4'(sent), r.ovf, r.sign, r.mag[23:0]});
          sent++;
        end
      end else begin
        v24 = 1'b0;
      end
      @(negedge clk);
    end
    v24 = 1'b0;
    ordy24 = 1'b1;
    check("b2b_count", 64'(got), 64'd16);
    @(negedge clk);
  endtask

  int   rsent, rgot;
  res_t rr;
  logic [63:0] q8[$];

  initial begin
    rst = 1'b1;
    v24 = 0; a24 = 0; b24 = 0; sa24 = 0; sb24 = 0; tag24 = 0; ordy24 = 1;
    v8 = 0;  a8 = 0;  b8 = 0;  sa8 = 0;  sb8 = 0;  tag8 = 0;  ordy8 = 1;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", {63'd0, ov24}, 64'd0);
    check("rst_in_ready",  {63'd0, rdy24}, 64'd1);
    check("rst_outputs",   {34'd0, ot24, of24, sg24, o24}, 64'd0);
    check("rst_out_valid8", {63'd0, ov8}, 64'd0);
`ifdef FR_ADDER_LZC_EN
    check("rst_lzc", {59'd0, lz24}, 64'd0);
`endif
    rst = 1'b0;

    // Directed WIDTH=24 vectors: name, in1, s1, in2, s2, tag, out, sign, ovf, lzc
    run24("msb_carry",   24'h800000, 0, 24'h800000, 0, 4'h1, 24'h000000, 0, 1, 24);
    run24("diff_neg",    24'h000005, 0, 24'h000009, 1, 4'h2, 24'h000004, 1, 0, 21);
    run24("diff_pos",    24'h000005, 1, 24'h000009, 0, 4'h3, 24'h000004, 0, 0, 21);
    run24("cancel",      24'h123456, 0, 24'h123456, 1, 4'h4, 24'h000000, 0, 0, 24);
    run24("cancel_sw",   24'h123456, 1, 24'h123456, 0, 4'h5, 24'h000000, 0, 0, 24);
    run24("wrap_neg",    24'hFFFFFF, 1, 24'h000001, 1, 4'h6, 24'h000000, 1, 1, 24);
    run24("borrow_long", 24'h800000, 1, 24'h000001, 0, 4'h7, 24'h7FFFFF, 1, 0, 1);
    run24("big_in2",     24'h000001, 0, 24'hFFFFFF, 1, 4'h8, 24'hFFFFFE, 1, 0, 0);
    run24("plain_add",   24'h00ABCD, 0, 24'h001234, 0, 4'h9, 24'h00BE01, 0, 0, 8);

    run8("w8_carry", 8'hFF, 0, 8'h01, 0, 4'hC, 8'h00, 0, 1, 8);

    b2b24();

    // Five operations in flight, then reset: nothing may emerge.
    ordy24 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v24 = 1'b1; a24 = 24'(i + 1); b24 = 24'd7; sa24 = 0; sb24 = 0; tag24 = 4'(i);
      @(negedge clk);
    end
    v24 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {63'd0, ov24}, 64'd0);
    check("midrst_in_ready",  {63'd0, rdy24}, 64'd1);
    @(negedge clk);
    check("midrst_out_valid_held", {63'd0, ov24}, 64'd0);
    rst = 1'b0;
    // Accepted on the first edge after release; any stale result would arrive early.
    run24("post_reset", 24'h000010, 1, 24'h000020, 1, 4'hA, 24'h000030, 1, 0, 18);

    // WIDTH=8 random sign-magnitude stream against the reference model.
    rsent = 0;
    rgot  = 0;
    ordy8 = 1'b1;
    for (int cyc = 0; cyc < 300 && rgot < 40; cyc++) begin
      if (ov8) begin
        if (q8.size() == 0) begin
          check("rnd_extra_result", 64'd1, 64'd0);
        end else begin
          check("rnd_result", {50'd0, ot8, of8, sg8, o8}, q8.pop_front());
          rgot++;
        end
      end
      if (rsent < 40) begin
        a8  = 8'($urandom_range(0, 255));
        b8  = (rsent % 5 == 4) ? a8 : 8'($urandom_range(0, 255));
        sa8 = 1'($urandom_range(0, 1));
        sb8 = 1'($urandom_range(0, 1));
        tag8 = 4'(rsent);
        v8 = 1'b1;
        rr = ref_add(8, {56'd0, a8}, sa8, {56'd0, b8}, sb8);
        q8.push_back({50'd0, 4'(rsent), rr.ovf, rr.sign, rr.mag[7:0]});
        rsent++;
      end else begin
        v8 = 1'b0;
      end
      @(negedge clk);
    end
    check("rnd_count", 64'(rgot), 64'd40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
